// File: rtl/coco_sram_arbiter_if.sv
// Requester-side bundle for coco_sram_arbiter: per-port select strobes, request fields and results.
interface coco_sram_arbiter_if #(
   parameter int NPORTS = 3,
   parameter int AW     = 16,
   parameter int DW     = 8
);
   logic [NPORTS-1:0]    req_sel_n;
   logic [NPORTS-1:0]    req_en;
   logic [NPORTS-1:0]    req_rw;
   logic [NPORTS*AW-1:0] req_addr;
   logic [NPORTS*DW-1:0] req_wdata;
   logic [NPORTS*DW-1:0] req_rdata;
   logic [NPORTS-1:0]    req_done;
   logic [NPORTS-1:0]    req_pending;
   logic [NPORTS-1:0]    req_overrun;

   modport master (
      output req_sel_n, req_en, req_rw, req_addr, req_wdata,
      input  req_rdata, req_done, req_pending, req_overrun
   );

   modport slave (
      input  req_sel_n, req_en, req_rw, req_addr, req_wdata,
      output req_rdata, req_done, req_pending, req_overrun
   );
endinterface

// File: rtl/coco_sram_arbiter.sv
// N-port arbiter for the shared asynchronous SRAM: synchronised select strobes, one queued
// request per port, fixed or round-robin grant and a fixed-length read/write cycle.
module coco_sram_arbiter #(
   parameter int NPORTS        = 3,
   parameter int AW            = 16,
   parameter int DW            = 8,
   parameter int ACCESS_CYCLES = 3,
   parameter int RR_MODE       = 0
) (
   input  logic               clock_50,
   input  logic               reset_n,
   coco_sram_arbiter_if.slave bus,
   output logic               busy,
   output logic [AW-1:0]      sram_addr,
   inout  wire  [DW-1:0]      sram_dq,
   output logic               sram_we_n,
   output logic               sram_oe_n,
   output logic               sram_ce_n
);
   localparam int CW = $clog2(ACCESS_CYCLES + 1);
   localparam int IW = (NPORTS > 1) ? $clog2(NPORTS) : 1;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ACCESS  = 2'd1,
      RECOVER = 2'd2
   } state_t;

   state_t                    state_q, state_d;
   logic [NPORTS-1:0][2:0]    sync_q, sync_d;
   logic [NPORTS-1:0]         pending_q, pending_d;
   logic [NPORTS-1:0]         overrun_q, overrun_d;
   logic [NPORTS-1:0][DW-1:0] rdata_q, rdata_d;
   logic [IW-1:0]             idx_q, idx_d;
   logic [IW-1:0]             last_grant_q, last_grant_d;
   logic                      rw_q, rw_d;
   logic [AW-1:0]             addr_q, addr_d;
   logic [DW-1:0]             wdata_q, wdata_d;
   logic [CW-1:0]             count_q, count_d;

   logic [NPORTS-1:0][AW-1:0] addr_arr;
   logic [NPORTS-1:0][DW-1:0] wdata_arr;
   logic [NPORTS-1:0]         edge_det;
   logic [NPORTS-1:0]         in_service;
   logic [IW-1:0]             winner;
   logic [IW:0]               rr_sum;
   logic                      any_pending;
   logic                      grant;
   logic                      last_cycle;
   logic                      dq_drive;

   assign addr_arr    = bus.req_addr;
   assign wdata_arr   = bus.req_wdata;
   assign any_pending = |pending_q;
   assign grant       = (state_q == IDLE) && any_pending;
   assign last_cycle  = (state_q == ACCESS) && (count_q == CW'(1));

   // A falling edge is seen two flops deep so the pending logic never samples a metastable bit.
   always_comb begin
      sync_d     = sync_q;
      edge_det   = '0;
      in_service = '0;
      for (int i = 0; i < NPORTS; i++) begin
         sync_d[i]     = {sync_q[i][1:0], bus.req_sel_n[i]};
         edge_det[i]   = (sync_q[i][2:1] == 2'b10) && bus.req_en[i];
         in_service[i] = (state_q != IDLE) && (idx_q == IW'(i));
      end
   end

   // Round-robin scans downward from the farthest slot so the nearest pending port after last_grant wins.
   always_comb begin
      winner = '0;
      rr_sum = '0;
      if (RR_MODE == 0) begin
         for (int i = NPORTS - 1; i >= 0; i--) begin
            if (pending_q[i]) winner = IW'(i);
         end
      end else begin
         for (int k = NPORTS; k >= 1; k--) begin
            rr_sum = {1'b0, last_grant_q} + (IW+1)'(k);
            if (rr_sum >= (IW+1)'(NPORTS)) rr_sum = rr_sum - (IW+1)'(NPORTS);
            if (pending_q[rr_sum[IW-1:0]]) winner = rr_sum[IW-1:0];
         end
      end
   end

   // A new edge always re-arms pending, even in the grant cycle; only a queued, unserved port overruns.
   always_comb begin
      pending_d = pending_q;
      overrun_d = overrun_q;
      for (int i = 0; i < NPORTS; i++) begin
         if (grant && (winner == IW'(i))) pending_d[i] = 1'b0;
         if (edge_det[i]) begin
            if (pending_q[i] && !in_service[i]) overrun_d[i] = 1'b1;
            pending_d[i] = 1'b1;
         end
      end
   end

   always_comb begin
      state_d      = state_q;
      idx_d        = idx_q;
      last_grant_d = last_grant_q;
      rw_d         = rw_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      count_d      = count_q;
      rdata_d      = rdata_q;
      case (state_q)
         IDLE: begin
            if (any_pending) begin
               state_d      = ACCESS;
               idx_d        = winner;
               last_grant_d = winner;
               rw_d         = bus.req_rw[winner];
               addr_d       = addr_arr[winner];
               wdata_d      = wdata_arr[winner];
               count_d      = CW'(ACCESS_CYCLES);
            end
         end
         ACCESS: begin
            count_d = count_q - CW'(1);
            if (last_cycle) begin
               state_d = RECOVER;
               if (rw_q) rdata_d[idx_q] = sram_dq;
            end
         end
         RECOVER: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock_50 or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= IDLE;
         sync_q       <= '1;
         pending_q    <= '0;
         overrun_q    <= '0;
         rdata_q      <= '0;
         idx_q        <= '0;
         last_grant_q <= IW'(NPORTS - 1);
         rw_q         <= 1'b0;
         addr_q       <= '0;
         wdata_q      <= '0;
         count_q      <= '0;
      end else begin
         state_q      <= state_d;
         sync_q       <= sync_d;
         pending_q    <= pending_d;
         overrun_q    <= overrun_d;
         rdata_q      <= rdata_d;
         idx_q        <= idx_d;
         last_grant_q <= last_grant_d;
         rw_q         <= rw_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         count_q      <= count_d;
      end
   end

   // Write enable rises one cycle before the bus is released so the part sees data hold time.
   assign dq_drive        = (state_q == ACCESS) && !rw_q;
   assign sram_dq         = dq_drive ? wdata_q : {DW{1'bz}};
   assign sram_we_n       = !(dq_drive && !last_cycle);
   assign sram_oe_n       = !((state_q == ACCESS) && rw_q);
   assign sram_ce_n       = 1'b0;
   assign sram_addr       = addr_q;
   assign busy            = (state_q != IDLE);
   assign bus.req_rdata   = rdata_q;
   assign bus.req_done    = in_service & {NPORTS{state_q == RECOVER}};
   assign bus.req_pending = pending_q | in_service;
   assign bus.req_overrun = overrun_q;
endmodule

// File: tb/tb_coco_sram_arbiter.sv
// Directed bench for coco_sram_arbiter: a fixed-priority 3-cycle build and a round-robin 5-cycle
// build, each with its own SRAM model.
module tb_coco_sram_arbiter;
   logic        clock_50;
   logic        reset_n;
   int          checks;
   int          failures;

   logic        busy0, busy1, we_n0, we_n1, oe_n0, oe_n1, ce_n0, ce_n1;
   logic [15:0] addr0, addr1;
   wire  [7:0]  dq0, dq1;
   logic [7:0]  mem0 [0:65535];

   int          rec_n;
   logic [2:0]  rec_done [8];
   int          rec_at [8];

   coco_sram_arbiter_if #(.NPORTS(3), .AW(16), .DW(8)) bus0 ();
   coco_sram_arbiter_if #(.NPORTS(3), .AW(16), .DW(8)) bus1 ();

   coco_sram_arbiter #(.NPORTS(3), .AW(16), .DW(8), .ACCESS_CYCLES(3), .RR_MODE(0)) u_dut0 (
      .clock_50(clock_50), .reset_n(reset_n), .bus(bus0.slave), .busy(busy0),
      .sram_addr(addr0), .sram_dq(dq0), .sram_we_n(we_n0), .sram_oe_n(oe_n0), .sram_ce_n(ce_n0)
   );

   coco_sram_arbiter #(.NPORTS(3), .AW(16), .DW(8), .ACCESS_CYCLES(5), .RR_MODE(1)) u_dut1 (
      .clock_50(clock_50), .reset_n(reset_n), .bus(bus1.slave), .busy(busy1),
      .sram_addr(addr1), .sram_dq(dq1), .sram_we_n(we_n1), .sram_oe_n(oe_n1), .sram_ce_n(ce_n1)
   );

   initial clock_50 = 1'b0;
   always #10 clock_50 = ~clock_50;

   // SRAM models: a writable array for the first build, an address-derived ROM for the second.
   assign dq0 = (oe_n0 == 1'b0) ? mem0[addr0] : 8'hzz;
   always @(posedge we_n0) if (reset_n) mem0[addr0] <= dq0;
   assign dq1 = (oe_n1 == 1'b0) ? (addr1[7:0] ^ 8'h5A) : 8'hzz;

   task automatic pulse0(input logic [2:0] mask);
      bus0.req_sel_n = bus0.req_sel_n & ~mask;
      @(negedge clock_50);
      bus0.req_sel_n = bus0.req_sel_n | mask;
   endtask

   task automatic pulse1(input logic [2:0] mask);
      bus1.req_sel_n = bus1.req_sel_n & ~mask;
      @(negedge clock_50);
      bus1.req_sel_n = bus1.req_sel_n | mask;
   endtask

   task automatic record0(input int last);
      rec_n = 0;
      for (int j = 2; j <= last; j++) begin
         @(negedge clock_50);
         if (bus0.req_done != 3'b000) begin
            if (rec_n < 8) begin rec_done[rec_n] = bus0.req_done; rec_at[rec_n] = j; end
            rec_n++;
         end
      end
   endtask

   task automatic record1(input int last);
      rec_n = 0;
      for (int j = 2; j <= last; j++) begin
         @(negedge clock_50);
         if (bus1.req_done != 3'b000) begin
            if (rec_n < 8) begin rec_done[rec_n] = bus1.req_done; rec_at[rec_n] = j; end
            rec_n++;
         end
      end
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      repeat (3) @(negedge clock_50);
      checks++; if (we_n0 !== 1'b1) begin failures++; $display("[TB] FAIL reset_we_n: got %b expected 1", we_n0); end
      checks++; if (oe_n0 !== 1'b1) begin failures++; $display("[TB] FAIL reset_oe_n: got %b expected 1", oe_n0); end
      checks++; if (ce_n0 !== 1'b0) begin failures++; $display("[TB] FAIL reset_ce_n: got %b expected 0", ce_n0); end
      checks++; if (addr0 !== 16'h0000) begin failures++; $display("[TB] FAIL reset_addr: got %h expected 0000", addr0); end
      checks++; if ({busy0, busy1} !== 2'b00) begin failures++; $display("[TB] FAIL reset_busy: got %b expected 00", {busy0, busy1}); end
      checks++; if (bus0.req_done !== 3'b000) begin failures++; $display("[TB] FAIL reset_done: got %b expected 000", bus0.req_done); end
      checks++; if (bus0.req_pending !== 3'b000) begin failures++; $display("[TB] FAIL reset_pending: got %b expected 000", bus0.req_pending); end
      checks++; if (bus0.req_overrun !== 3'b000) begin failures++; $display("[TB] FAIL reset_overrun: got %b expected 000", bus0.req_overrun); end
      checks++; if (bus0.req_rdata !== 24'h000000) begin failures++; $display("[TB] FAIL reset_rdata: got %h expected 000000", bus0.req_rdata); end
      checks++; if ({oe_n1, we_n1, ce_n1} !== 3'b110) begin failures++; $display("[TB] FAIL reset_pins1: got %b expected 110", {oe_n1, we_n1, ce_n1}); end
      reset_n = 1'b1;
      repeat (2) @(negedge clock_50);
      checks++; if ({busy0, bus0.req_pending} !== 4'b0000) begin failures++; $display("[TB] FAIL post_reset_idle: got %b expected 0000", {busy0, bus0.req_pending}); end
   endtask

   task automatic test_single_read();
      logic       exp_oe, exp_busy;
      logic [2:0] exp_pend, exp_done;
      logic [7:0] exp_rd;
      bus0.req_addr[16 +: 16] = 16'h8123;
      bus0.req_rw[1] = 1'b1;
      pulse0(3'b010);
      for (int j = 2; j <= 8; j++) begin
         @(negedge clock_50);
         exp_oe   = !(j >= 4 && j <= 6);
         exp_busy = (j >= 4 && j <= 7);
         exp_pend = (j >= 3 && j <= 7) ? 3'b010 : 3'b000;
         exp_done = (j == 7) ? 3'b010 : 3'b000;
         exp_rd   = (j >= 7) ? 8'hA5 : 8'h00;
         checks++; if (oe_n0 !== exp_oe) begin failures++; $display("[TB] FAIL read_oe_n j=%0d: got %b expected %b", j, oe_n0, exp_oe); end
         checks++; if (busy0 !== exp_busy) begin failures++; $display("[TB] FAIL read_busy j=%0d: got %b expected %b", j, busy0, exp_busy); end
         checks++; if (bus0.req_pending !== exp_pend) begin failures++; $display("[TB] FAIL read_pending j=%0d: got %b expected %b", j, bus0.req_pending, exp_pend); end
         checks++; if (bus0.req_done !== exp_done) begin failures++; $display("[TB] FAIL read_done j=%0d: got %b expected %b", j, bus0.req_done, exp_done); end
         checks++; if (bus0.req_rdata[15:8] !== exp_rd) begin failures++; $display("[TB] FAIL read_rdata j=%0d: got %h expected %h", j, bus0.req_rdata[15:8], exp_rd); end
         if (j >= 4 && j <= 6) begin
            checks++; if (addr0 !== 16'h8123) begin failures++; $display("[TB] FAIL read_addr j=%0d: got %h expected 8123", j, addr0); end
         end
      end
   endtask

   task automatic test_write();
      logic       exp_we;
      logic [2:0] exp_done;
      bus0.req_addr[0 +: 16] = 16'h2000;
      bus0.req_wdata[0 +: 8] = 8'h3C;
      bus0.req_rw[0] = 1'b0;
      pulse0(3'b001);
      for (int j = 2; j <= 8; j++) begin
         @(negedge clock_50);
         exp_we   = !(j == 4 || j == 5);
         exp_done = (j == 7) ? 3'b001 : 3'b000;
         checks++; if (we_n0 !== exp_we) begin failures++; $display("[TB] FAIL write_we_n j=%0d: got %b expected %b", j, we_n0, exp_we); end
         checks++; if (oe_n0 !== 1'b1) begin failures++; $display("[TB] FAIL write_oe_n j=%0d: got %b expected 1", j, oe_n0); end
         checks++; if (bus0.req_done !== exp_done) begin failures++; $display("[TB] FAIL write_done j=%0d: got %b expected %b", j, bus0.req_done, exp_done); end
         if (j >= 4 && j <= 6) begin
            checks++; if (dq0 !== 8'h3C) begin failures++; $display("[TB] FAIL write_dq j=%0d: got %h expected 3c", j, dq0); end
            checks++; if (addr0 !== 16'h2000) begin failures++; $display("[TB] FAIL write_addr j=%0d: got %h expected 2000", j, addr0); end
         end
      end
      bus0.req_rw[0] = 1'b1;
      pulse0(3'b001);
      record0(8);
      checks++; if (rec_n != 1 || rec_done[0] !== 3'b001 || rec_at[0] != 7) begin failures++; $display("[TB] FAIL readback_done: got n=%0d done=%b at=%0d expected n=1 done=001 at=7", rec_n, rec_done[0], rec_at[0]); end
      checks++; if (bus0.req_rdata[7:0] !== 8'h3C) begin failures++; $display("[TB] FAIL readback_data: got %h expected 3c", bus0.req_rdata[7:0]); end
   endtask

   task automatic test_fixed_priority();
      logic [2:0] exp_d [3];
      int         exp_at [3];
      exp_d = '{3'b001, 3'b010, 3'b100};
      exp_at = '{7, 12, 17};
      bus0.req_addr = {16'h0030, 16'h0020, 16'h0010};
      bus0.req_rw = 3'b111;
      pulse0(3'b111);
      record0(24);
      checks++; if (rec_n != 3) begin failures++; $display("[TB] FAIL fixed_count: got %0d expected 3", rec_n); end
      for (int k = 0; k < 3; k++) begin
         checks++; if (rec_done[k] !== exp_d[k] || rec_at[k] != exp_at[k]) begin failures++; $display("[TB] FAIL fixed_order[%0d]: got %b at %0d expected %b at %0d", k, rec_done[k], rec_at[k], exp_d[k], exp_at[k]); end
      end
      checks++; if (bus0.req_rdata !== 24'h332211) begin failures++; $display("[TB] FAIL fixed_rdata: got %h expected 332211", bus0.req_rdata); end
   endtask

   task automatic test_restrobe_in_service();
      bus0.req_addr[16 +: 16] = 16'h8123;
      pulse0(3'b010);
      repeat (2) @(negedge clock_50);
      bus0.req_sel_n[1] = 1'b0;
      @(negedge clock_50);
      bus0.req_sel_n[1] = 1'b1;
      rec_n = 0;
      for (int j = 5; j <= 16; j++) begin
         @(negedge clock_50);
         if (bus0.req_done != 3'b000) begin
            if (rec_n < 8) begin rec_done[rec_n] = bus0.req_done; rec_at[rec_n] = j; end
            rec_n++;
         end
      end
      checks++; if (rec_n != 2 || rec_done[0] !== 3'b010 || rec_at[0] != 7 || rec_done[1] !== 3'b010 || rec_at[1] != 12) begin failures++; $display("[TB] FAIL restrobe_done: got n=%0d %b@%0d %b@%0d expected n=2 010@7 010@12", rec_n, rec_done[0], rec_at[0], rec_done[1], rec_at[1]); end
      checks++; if (bus0.req_overrun !== 3'b000) begin failures++; $display("[TB] FAIL restrobe_overrun: got %b expected 000", bus0.req_overrun); end
   endtask

   task automatic test_overrun();
      logic [2:0] exp_ov;
      pulse0(3'b101);
      rec_n = 0;
      for (int j = 2; j <= 22; j++) begin
         @(negedge clock_50);
         if (bus0.req_done != 3'b000) begin
            if (rec_n < 8) begin rec_done[rec_n] = bus0.req_done; rec_at[rec_n] = j; end
            rec_n++;
         end
         if (j == 5 || j == 6 || j == 12) begin
            exp_ov = (j >= 6) ? 3'b100 : 3'b000;
            checks++; if (bus0.req_overrun !== exp_ov) begin failures++; $display("[TB] FAIL overrun j=%0d: got %b expected %b", j, bus0.req_overrun, exp_ov); end
         end
         if (j == 13) begin
            checks++; if (bus0.req_pending !== 3'b100) begin failures++; $display("[TB] FAIL requeue_pending: got %b expected 100", bus0.req_pending); end
         end
         if (j == 3 || j == 8) bus0.req_sel_n[2] = 1'b0;
         if (j == 4 || j == 9) bus0.req_sel_n[2] = 1'b1;
      end
      checks++; if (rec_n != 3) begin failures++; $display("[TB] FAIL overrun_count: got %0d expected 3", rec_n); end
      checks++; if (rec_done[0] !== 3'b001 || rec_at[0] != 7) begin failures++; $display("[TB] FAIL overrun_first: got %b@%0d expected 001@7", rec_done[0], rec_at[0]); end
      checks++; if (rec_done[1] !== 3'b100 || rec_at[1] != 12) begin failures++; $display("[TB] FAIL overrun_second: got %b@%0d expected 100@12", rec_done[1], rec_at[1]); end
      checks++; if (rec_done[2] !== 3'b100 || rec_at[2] != 17) begin failures++; $display("[TB] FAIL overrun_third: got %b@%0d expected 100@17", rec_done[2], rec_at[2]); end
   endtask

   task automatic test_req_en();
      bus0.req_en[1] = 1'b0;
      pulse0(3'b010);
      for (int j = 2; j <= 10; j++) begin
         @(negedge clock_50);
         checks++; if ({busy0, bus0.req_pending, oe_n0, we_n0} !== 6'b000011) begin failures++; $display("[TB] FAIL req_en_ignored j=%0d: got %b expected 000011", j, {busy0, bus0.req_pending, oe_n0, we_n0}); end
      end
      bus0.req_en[1] = 1'b1;
      @(negedge clock_50);
   endtask

   task automatic test_round_robin();
      logic       exp_oe;
      logic [2:0] exp_done;
      logic [2:0] exp_d [3];
      int         exp_at [3];
      bus1.req_addr = {16'h0062, 16'h0051, 16'h0040};
      bus1.req_rw = 3'b111;
      pulse1(3'b001);
      for (int j = 2; j <= 10; j++) begin
         @(negedge clock_50);
         exp_oe   = !(j >= 4 && j <= 8);
         exp_done = (j == 9) ? 3'b001 : 3'b000;
         checks++; if (oe_n1 !== exp_oe) begin failures++; $display("[TB] FAIL rr_oe_n j=%0d: got %b expected %b", j, oe_n1, exp_oe); end
         checks++; if (bus1.req_done !== exp_done) begin failures++; $display("[TB] FAIL rr_done j=%0d: got %b expected %b", j, bus1.req_done, exp_done); end
      end
      checks++; if (bus1.req_rdata[7:0] !== 8'h1A) begin failures++; $display("[TB] FAIL rr_rdata0: got %h expected 1a", bus1.req_rdata[7:0]); end
      exp_d = '{3'b010, 3'b100, 3'b001};
      exp_at = '{9, 16, 23};
      pulse1(3'b111);
      record1(30);
      checks++; if (rec_n != 3) begin failures++; $display("[TB] FAIL rr_count: got %0d expected 3", rec_n); end
      for (int k = 0; k < 3; k++) begin
         checks++; if (rec_done[k] !== exp_d[k] || rec_at[k] != exp_at[k]) begin failures++; $display("[TB] FAIL rr_order[%0d]: got %b at %0d expected %b at %0d", k, rec_done[k], rec_at[k], exp_d[k], exp_at[k]); end
      end
      checks++; if (bus1.req_rdata !== 24'h380B1A) begin failures++; $display("[TB] FAIL rr_rdata: got %h expected 380b1a", bus1.req_rdata); end
   endtask

   task automatic test_reset_abort();
      bus0.req_addr[0 +: 16] = 16'h3000;
      bus0.req_wdata[0 +: 8] = 8'h77;
      bus0.req_rw[0] = 1'b0;
      pulse0(3'b001);
      repeat (3) @(negedge clock_50);
      checks++; if (we_n0 !== 1'b0) begin failures++; $display("[TB] FAIL abort_precondition_we_n: got %b expected 0", we_n0); end
      #2 reset_n = 1'b0;
      #1;
      checks++; if ({we_n0, oe_n0, busy0} !== 3'b110) begin failures++; $display("[TB] FAIL abort_pins: got %b expected 110", {we_n0, oe_n0, busy0}); end
      checks++; if (addr0 !== 16'h0000) begin failures++; $display("[TB] FAIL abort_addr: got %h expected 0000", addr0); end
      checks++; if ({bus0.req_done, bus0.req_pending, bus0.req_overrun} !== 9'b0) begin failures++; $display("[TB] FAIL abort_status: got %b expected 000000000", {bus0.req_done, bus0.req_pending, bus0.req_overrun}); end
      checks++; if (bus0.req_rdata !== 24'h000000) begin failures++; $display("[TB] FAIL abort_rdata: got %h expected 000000", bus0.req_rdata); end
      repeat (2) @(negedge clock_50);
      checks++; if (bus0.req_done !== 3'b000) begin failures++; $display("[TB] FAIL abort_no_done: got %b expected 000", bus0.req_done); end
      reset_n = 1'b1;
      @(negedge clock_50);
      bus0.req_addr[16 +: 16] = 16'h8123;
      bus0.req_rw[1] = 1'b1;
      pulse0(3'b010);
      record0(9);
      checks++; if (rec_n != 1 || rec_done[0] !== 3'b010 || rec_at[0] != 7) begin failures++; $display("[TB] FAIL after_abort_done: got n=%0d %b@%0d expected n=1 010@7", rec_n, rec_done[0], rec_at[0]); end
      checks++; if (bus0.req_rdata[15:8] !== 8'hA5) begin failures++; $display("[TB] FAIL after_abort_rdata: got %h expected a5", bus0.req_rdata[15:8]); end
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      reset_n  = 1'b0;
      mem0[16'h8123] = 8'hA5;
      mem0[16'h0010] = 8'h11;
      mem0[16'h0020] = 8'h22;
      mem0[16'h0030] = 8'h33;
      bus0.req_sel_n = 3'b111; bus0.req_en = 3'b111; bus0.req_rw = 3'b000;
      bus0.req_addr = '0; bus0.req_wdata = '0;
      bus1.req_sel_n = 3'b111; bus1.req_en = 3'b111; bus1.req_rw = 3'b000;
      bus1.req_addr = '0; bus1.req_wdata = '0;
      $display("[TB] starting coco_sram_arbiter bench");
      test_reset();
      test_single_read();
      test_write();
      test_fixed_priority();
      test_restrobe_in_service();
      test_overrun();
      test_req_en();
      test_round_robin();
      test_reset_abort();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/coco_sram_arbiter.md
# coco_sram_arbiter

Parametrised N-port arbiter for the shared asynchronous SRAM on the CoCo FDC/ROM board. It synchronises each requester's asynchronous select strobe to clock_50, queues one pending request per port, and grants the SRAM by fixed or round-robin priority. It runs a configurable-length read or write cycle and returns per-port registered read data with a completion pulse. It replaces the hard-wired two-requester (CoCo CTS / AVR) SRAM path and sits between the bus front-ends and the SRAM pins.

## Interface
- NPORTS, 3, number of requesters (2..8); port 0 = AVR, 1 = CoCo CTS, 2 = spare.
- AW, 16, SRAM address width.
- DW, 8, SRAM data width.
- ACCESS_CYCLES, 3, clock_50 cycles per SRAM access (>=2; 3 = 60 ns for 55 ns parts).
- RR_MODE, 0, 0 = fixed priority (lowest index wins); 1 = round-robin.

- clock_50  in  1  system clock, 50 MHz.
- reset_n  in  1  asynchronous, active-low reset.
- req_sel_n  in  NPORTS  asynchronous select strobe per port; falling edge = new request.
- req_en  in  NPORTS  edge qualifier per port (e.g. c_power); edges while 0 are ignored.
- req_rw  in  NPORTS  1 = read, 0 = write; sampled at grant.
- req_addr  in  NPORTS*AW  per-port address, port i at [i*AW +: AW]; sampled at grant.
- req_wdata  in  NPORTS*DW  per-port write data; sampled at grant.
- req_rdata  out  NPORTS*DW  per-port read data register; holds until that port's next read completes.
- req_done  out  NPORTS  one-cycle completion pulse.
- req_pending  out  NPORTS  request queued or in service.
- req_overrun  out  NPORTS  sticky; set when an edge arrives while the port is already pending and not in service; cleared only by reset.
- busy  out  1  arbiter not IDLE.
- sram_addr  out  AW  SRAM address.
- sram_dq  inout  DW  SRAM data; driven only during write ACCESS, otherwise high-Z.
- sram_we_n  out  1  write enable, active low.
- sram_oe_n  out  1  output enable, active low; low only during read ACCESS.
- sram_ce_n  out  1  tied 0.

## Operation
- Synchroniser: a 3-flop shift register per port on req_sel_n. A falling edge is sync[2:1] == 2'b10.
- Pending: a qualified edge (req_en = 1) sets pending[i]. An edge with pending[i] already set and i not in service is dropped and sets req_overrun[i].
- FSM states: IDLE, ACCESS, RECOVER.
- IDLE: if any pending bit is set, select the winner.
  - RR_MODE = 0: lowest index.
  - RR_MODE = 1: first pending index after last_grant, wrapping NPORTS-1 -> 0. last_grant resets to NPORTS-1, so port 0 wins first.
- On grant:
  - Latch the winner index, rw, addr and wdata.
  - Clear pending[winner].
  - Load the counter with ACCESS_CYCLES. Counter width is clog2(ACCESS_CYCLES+1).
  - Go to ACCESS.
- ACCESS:
  - sram_addr = latched address.
  - Read: sram_oe_n = 0.
  - Write: drive sram_dq = latched wdata for all ACCESS_CYCLES cycles; sram_we_n = 0 for the first ACCESS_CYCLES-1 cycles, and 1 on the last cycle (data hold).
  - Decrement the counter each cycle.
  - On the last cycle (count == 1): a read captures sram_dq into req_rdata[winner]. Go to RECOVER.
- RECOVER: one cycle with req_done[winner] = 1, bus high-Z, sram_oe_n = sram_we_n = 1. Then IDLE.
- An edge on the port in service sets its pending bit again: a new request, not an overrun.
- An edge arriving in the same cycle that pending is cleared by grant: set wins.
- Reset values:
  - sram_we_n = sram_oe_n = 1, sram_dq high-Z, sram_addr = 0.
  - req_rdata = 0, req_done = 0, req_pending = 0, req_overrun = 0, busy = 0.
  - Synchronisers all 1, state IDLE.
- Reset mid-ACCESS aborts immediately (asynchronous) with no done pulse. The partial SRAM write is not guaranteed.

## Timing
- Let E be the cycle the synchronised edge is detected. pending[i] = 1 from E+1.
- Grant decision in cycle E+1 if IDLE. ACCESS occupies E+2 .. E+1+ACCESS_CYCLES.
- req_done and the new req_rdata are visible in E+2+ACCESS_CYCLES. Back in IDLE at E+3+ACCESS_CYCLES.
- Back-to-back grant throughput: one access per ACCESS_CYCLES+2 cycles.
- Port inputs must remain stable from the strobe until req_done or until pending drops.
- Worst-case wait for any port:
  - Round-robin: NPORTS-1 accesses.
  - Fixed priority: unbounded for high-index ports under a saturating port 0.

## Test plan
- Single read, port 1: SRAM model holds 0xA5 at 0x8123; port 1 addr = 0x8123, rw = 1, strobe low -> oe_n low for exactly 3 cycles with addr 0x8123, req_rdata[1] = 0xA5, one-cycle req_done[1].
- Write, port 0: addr 0x2000, wdata 0x3C -> we_n low 2 cycles then high 1 cycle with dq = 0x3C throughout; readback returns 0x3C.
- Simultaneous strobes on ports 0, 1, 2 with RR_MODE = 0 -> service order 0, 1, 2. With RR_MODE = 1 and last_grant = 0 -> order 1, 2, 0.
- Strobes on port 2 twice before grant (port 0 holding the bus) -> req_overrun[2] = 1, exactly one port-2 access. A third strobe during port 2's ACCESS -> new pending, no overrun change.
- req_en[1] = 0 with strobe -> no pending, no SRAM activity. ACCESS_CYCLES = 5 build -> oe_n low 5 cycles, done at E+7.
- reset_n low during write ACCESS -> we_n high and dq high-Z within the same cycle, no req_done. After release, all outputs are at reset values and the next request is served normally.
